// File: rtl/pll_cmd_spi_master.sv
// SPI initiator for the PLL-board command link: shifts one 51- or 45-bit command
// frame out MSB first and collects the 6-bit lock reply from the first clock rises.
module pll_cmd_spi_master #(
  parameter int unsigned CMD_BIT_NUM   = 51,
  parameter int unsigned SHORT_BIT_NUM = 45,
  parameter int unsigned REPLY_BIT_NUM = 6,
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned CS_SETUP      = 2,
  parameter int unsigned CS_HOLD       = 2,
  parameter int unsigned GAP_CYCLES    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     long_cmd,
  input  logic [CMD_BIT_NUM-1:0]   cmd_data,
  output logic                     busy,
  output logic                     done,
  output logic [REPLY_BIT_NUM-1:0] reply,
  output logic                     spi_clk,
  output logic                     spi_cs,
  output logic                     spi_mosi,
  input  logic                     spi_miso
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;

  localparam logic [15:0] SETUP_LD = 16'(CS_SETUP - 1);
  localparam logic [15:0] DIV_LD   = 16'(CLK_DIV - 1);
  localparam logic [15:0] HOLD_LD  = 16'(CS_HOLD - 1);
  localparam logic [15:0] GAP_LD   = 16'(GAP_CYCLES - 1);
  localparam logic [5:0]  N_LONG   = 6'(CMD_BIT_NUM);
  localparam logic [5:0]  N_SHORT  = 6'(SHORT_BIT_NUM);
  localparam logic [5:0]  N_REPLY  = 6'(REPLY_BIT_NUM);
  localparam int unsigned PAD_W    = CMD_BIT_NUM - SHORT_BIT_NUM;

  state_t                   state_q, state_d;
  logic [15:0]              timer_q, timer_d;
  logic [5:0]               bit_idx_q, bit_idx_d;
  logic [5:0]               nbits_q, nbits_d;
  logic [CMD_BIT_NUM-1:0]   shreg_q, shreg_d;
  logic [REPLY_BIT_NUM-1:0] rx_q, rx_d;
  logic [REPLY_BIT_NUM-1:0] reply_q, reply_d;
  logic                     cs_q, cs_d;
  logic                     sclk_q, sclk_d;
  logic                     mosi_q, mosi_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     tdone;
  logic [5:0]               bit_nxt;

  assign tdone   = (timer_q == 16'd0);
  assign bit_nxt = bit_idx_q + 6'd1;

  // Short frames are left-aligned in the shifter so the outgoing bit is always the MSB.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    nbits_d   = nbits_q;
    shreg_d   = shreg_q;
    rx_d      = rx_q;
    reply_d   = reply_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (long_cmd) begin
            shreg_d = cmd_data;
            nbits_d = N_LONG;
            mosi_d  = cmd_data[CMD_BIT_NUM-1];
          end else begin
            shreg_d = {cmd_data[SHORT_BIT_NUM-1:0], {PAD_W{1'b0}}};
            nbits_d = N_SHORT;
            mosi_d  = cmd_data[SHORT_BIT_NUM-1];
          end
          bit_idx_d = 6'd0;
          rx_d      = '0;
          timer_d   = SETUP_LD;
          cs_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (tdone) begin
          timer_d = DIV_LD;
          state_d = LOW;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      LOW: begin
        if (tdone) begin
          timer_d = DIV_LD;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      HIGH: begin
        if (timer_q == DIV_LD && bit_idx_q < N_REPLY) begin
          rx_d = {rx_q[REPLY_BIT_NUM-2:0], spi_miso};
        end
        if (tdone) begin
          bit_idx_d = bit_nxt;
          sclk_d    = 1'b0;
          if (bit_nxt < nbits_q) begin
            shreg_d = shreg_q << 1;
            mosi_d  = shreg_q[CMD_BIT_NUM-2];
            timer_d = DIV_LD;
            state_d = LOW;
          end else begin
            mosi_d  = 1'b0;
            timer_d = HOLD_LD;
            state_d = HOLD;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      HOLD: begin
        if (tdone) begin
          cs_d    = 1'b1;
          timer_d = GAP_LD;
          state_d = GAP;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      GAP: begin
        if (tdone) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          reply_d = rx_q;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= 16'd0;
      bit_idx_q <= 6'd0;
      reply_q   <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      reply_q   <= reply_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Payload registers are always reloaded on acceptance, so they carry no reset.
  always_ff @(posedge clk) begin
    nbits_q <= nbits_d;
    shreg_q <= shreg_d;
    rx_q    <= rx_d;
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign reply    = reply_q;
  assign spi_clk  = sclk_q;
  assign spi_cs   = cs_q;
  assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_pll_cmd_spi_master.sv
// Bench for pll_cmd_spi_master: a default-timing and a minimum-timing instance, each
// driven against a slave model that captures mosi and returns a lock pattern on miso.
module tb_pll_cmd_spi_master;

  localparam int CDIV [2] = '{4, 1};
  localparam int CSS  [2] = '{2, 1};
  localparam int CSH  [2] = '{2, 1};
  localparam int GAPC [2] = '{16, 1};

  logic        clk, rst;
  logic        start_i [2];
  logic        long_i  [2];
  logic [50:0] data_i  [2];
  logic [5:0]  pat_i   [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic [5:0]  reply_o [2];
  logic        sclk_o  [2];
  logic        cs_o    [2];
  logic        mosi_o  [2];
  logic        miso0 = 1'b0, miso1 = 1'b0;

  int errors = 0;
  int checks = 0;

  pll_cmd_spi_master u_dut0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .long_cmd(long_i[0]), .cmd_data(data_i[0]),
    .busy(busy_o[0]), .done(done_o[0]), .reply(reply_o[0]), .spi_clk(sclk_o[0]),
    .spi_cs(cs_o[0]), .spi_mosi(mosi_o[0]), .spi_miso(miso0)
  );

  pll_cmd_spi_master #(
    .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .GAP_CYCLES(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .long_cmd(long_i[1]), .cmd_data(data_i[1]),
    .busy(busy_o[1]), .done(done_o[1]), .reply(reply_o[1]), .spi_clk(sclk_o[1]),
    .spi_cs(cs_o[1]), .spi_mosi(mosi_o[1]), .spi_miso(miso1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave models: shift mosi on each rise, present the next reply bit after each fall.
  logic [50:0] cap0 = '0, cap1 = '0;
  int nr0 = 0, nr1 = 0, csl0 = 0, csl1 = 0, idx0 = 0, idx1 = 0;

  always @(posedge sclk_o[0]) if (!cs_o[0]) begin cap0 = {cap0[49:0], mosi_o[0]}; nr0++; end
  always @(posedge sclk_o[1]) if (!cs_o[1]) begin cap1 = {cap1[49:0], mosi_o[1]}; nr1++; end
  always @(negedge clk) if (!cs_o[0]) csl0++;
  always @(negedge clk) if (!cs_o[1]) csl1++;

  always @(cs_o[0] or negedge sclk_o[0]) begin
    if (cs_o[0]) begin
      idx0 = 0;
      miso0 = 1'b0;
    end else begin
      miso0 = (idx0 < 6) ? pat_i[0][5-idx0] : 1'($urandom);
      idx0++;
    end
  end

  always @(cs_o[1] or negedge sclk_o[1]) begin
    if (cs_o[1]) begin
      idx1 = 0;
      miso1 = 1'b0;
    end else begin
      miso1 = (idx1 < 6) ? pat_i[1][5-idx1] : 1'($urandom);
      idx1++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [50:0] rnd51();
    return 51'({$urandom(), $urandom()});
  endfunction

  // Called on a falling clk edge; the following rising edge is acceptance (cycle 0).
  task automatic kick(input int g, input bit lng, input logic [50:0] d, input logic [5:0] p);
    start_i[g] = 1'b1;
    long_i[g]  = lng;
    data_i[g]  = d;
    pat_i[g]   = p;
  endtask

  // Follows one accepted frame to its done cycle and compares against frame arithmetic.
  task automatic run(input int g, input int ign_a, input int ign_b);
    int n, cs_exp, done_exp, k, nr_s, csl_s;
    logic [50:0] d, mask, cap;
    logic [5:0] prev, pat;
    bit lng, ok_rep, ok_busy;
    lng  = long_i[g];
    d    = data_i[g];
    pat  = pat_i[g];
    prev = reply_o[g];
    n = lng ? 51 : 45;
    cs_exp   = CSS[g] + 2 * CDIV[g] * n + CSH[g];
    done_exp = 1 + cs_exp + GAPC[g];
    mask = lng ? {51{1'b1}} : {6'b0, {45{1'b1}}};
    @(posedge clk);
    nr_s  = (g == 0) ? nr0 : nr1;
    csl_s = (g == 0) ? csl0 : csl1;
    @(negedge clk);
    start_i[g] = 1'b0;
    data_i[g]  = rnd51();
    long_i[g]  = ~lng;
    k = 1;
    check($sformatf("cyc1_busy[%0d]", g), 64'(busy_o[g]), 64'd1);
    check($sformatf("cyc1_cs[%0d]", g), 64'(cs_o[g]), 64'd0);
    ok_rep = 1'b1;
    ok_busy = 1'b1;
    while (!done_o[g] && k < 3000) begin
      start_i[g] = (k == ign_a || k == ign_b);
      if (reply_o[g] !== prev) ok_rep = 1'b0;
      if (busy_o[g] !== 1'b1) ok_busy = 1'b0;
      @(negedge clk);
      k++;
    end
    start_i[g] = 1'b0;
    cap = (g == 0) ? cap0 : cap1;
    check($sformatf("done_cycle[%0d]", g), 64'(k), 64'(done_exp));
    check($sformatf("busy_at_done[%0d]", g), 64'(busy_o[g]), 64'd0);
    check($sformatf("busy_held[%0d]", g), 64'(ok_busy), 64'd1);
    check($sformatf("cs_low_cycles[%0d]", g), 64'(((g == 0) ? csl0 : csl1) - csl_s), 64'(cs_exp));
    check($sformatf("clk_rises[%0d]", g), 64'(((g == 0) ? nr0 : nr1) - nr_s), 64'(n));
    check($sformatf("captured[%0d]", g), 64'(cap & mask), 64'(d & mask));
    check($sformatf("reply[%0d]", g), 64'(reply_o[g]), 64'(pat));
    check($sformatf("reply_stable[%0d]", g), 64'(ok_rep), 64'd1);
  endtask

  initial begin
    logic [50:0] d;
    bit quiet;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      start_i[g] = 1'b0;
      long_i[g]  = 1'b0;
      data_i[g]  = '0;
      pat_i[g]   = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_cs[%0d]", g), 64'(cs_o[g]), 64'd1);
      check($sformatf("rst_clk[%0d]", g), 64'(sclk_o[g]), 64'd0);
      check($sformatf("rst_mosi[%0d]", g), 64'(mosi_o[g]), 64'd0);
      check($sformatf("rst_busy[%0d]", g), 64'(busy_o[g]), 64'd0);
      check($sformatf("rst_done[%0d]", g), 64'(done_o[g]), 64'd0);
      check($sformatf("rst_reply[%0d]", g), 64'(reply_o[g]), 64'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full alternating frame, then a short frame started in the done cycle.
    kick(0, 1'b1, 51'h5_5555_5555_5555, 6'b101101);
    run(0, -1, -1);
    d = {6'b111111, 4'd3, 12'd100, 25'h1ABCDEF, 4'b0001};
    kick(0, 1'b0, d, 6'b010010);
    run(0, -1, -1);

    // Starts during an active frame must not queue a second frame.
    repeat (3) @(negedge clk);
    kick(0, 1'b1, rnd51(), 6'($urandom));
    run(0, 5, 200);
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done_o[0] !== 1'b0 || cs_o[0] !== 1'b1) quiet = 1'b0;
    end
    check("no_extra_frame", 64'(quiet), 64'd1);

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(1, 5)) @(negedge clk);
      kick(0, 1'($urandom), rnd51(), 6'($urandom_range(1, 63)));
      run(0, -1, -1);
    end

    // Mid-frame reset aborts cleanly.
    @(negedge clk);
    kick(0, 1'b1, rnd51(), 6'b110011);
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (149) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs", 64'(cs_o[0]), 64'd1);
    check("abort_clk", 64'(sclk_o[0]), 64'd0);
    check("abort_busy", 64'(busy_o[0]), 64'd0);
    check("abort_reply", 64'(reply_o[0]), 64'd0);
    check("abort_done", 64'(done_o[0]), 64'd0);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (400) begin
      @(negedge clk);
      if (done_o[0] !== 1'b0 || cs_o[0] !== 1'b1) quiet = 1'b0;
    end
    check("abort_quiet", 64'(quiet), 64'd1);
    kick(0, 1'b1, rnd51(), 6'b011110);
    run(0, -1, -1);

    // Minimum-timing instance.
    @(negedge clk);
    kick(1, 1'b0, rnd51(), 6'($urandom));
    run(1, -1, -1);
    for (int i = 0; i < 3; i++) begin
      kick(1, 1'($urandom), rnd51(), 6'($urandom));
      run(1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
